// File: rtl/zero_cross_freq_meter_pkg.sv
// ----------------------------------------------------------------------------
// zero_cross_freq_meter_pkg
// Shared types and constants for the zero-crossing frequency meter:
//   - zcfm_state_e      : measurement FSM states (HUNT, MEASURE)
//   - ZCFM_* constants  : default parameter values of the meter
//   - zcfm_dividend_w() : width of the unscaled divider dividend
//   - zcfm_max()        : integer max used for width arithmetic
// ----------------------------------------------------------------------------
package zero_cross_freq_meter_pkg;

    typedef enum logic [0:0] {
        HUNT    = 1'b0,
        MEASURE = 1'b1
    } zcfm_state_e;

    localparam int          ZCFM_BITSIZE     = 24;
    localparam int          ZCFM_PHASESIZE   = 16;
    localparam int          ZCFM_LOG2PERIODS = 2;
    localparam int          ZCFM_COUNTSIZE   = 20;
    localparam logic [23:0] ZCFM_HYST        = 24'h010000;

    // Dividend 2^LOG2PERIODS << PHASESIZE needs PHASESIZE+LOG2PERIODS+1 bits.
    localparam int ZCFM_DIVIDEND_W = ZCFM_PHASESIZE + ZCFM_LOG2PERIODS + 1;

    function automatic int zcfm_dividend_w(input int phasesize, input int log2periods);
        return phasesize + log2periods + 1;
    endfunction

    function automatic int zcfm_max(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/zero_cross_freq_meter_seq_divider.sv
// ----------------------------------------------------------------------------
// seq_divider
// Unsigned restoring divider, one quotient bit per clock, QW+1 clocks per
// division (the first bit is resolved on the load edge). Quotients that do
// not fit in QW bits saturate to all-ones.
// Ports:
//   clk       : clock
//   reset     : synchronous active-high reset, returns to idle
//   abort     : synchronous discard of any division in flight (no done)
//   start     : load dividend/divisor and begin (ignored while busy)
//   dividend  : NW-bit unsigned numerator
//   divisor   : DW-bit unsigned denominator
//   busy      : division in progress
//   done      : one-cycle pulse, quotient valid from this cycle on
//   quotient  : QW-bit result (held until the next completion)
// ----------------------------------------------------------------------------
module seq_divider #(
    parameter int NW = 19,
    parameter int DW = 20,
    parameter int QW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          abort,
    input  logic          start,
    input  logic [NW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [QW-1:0] quotient
);

    // Working width holds both the dividend and the divisor shifted by QW.
    localparam int XW = (NW > DW + QW) ? NW : DW + QW;
    localparam int CW = $clog2(QW + 1);
    localparam logic [QW-1:0] Q_ALL_ONES = {QW{1'b1}};

    logic [XW-1:0] rem_r;
    logic [XW-1:0] dsh_r;
    logic [QW-1:0] q_r;
    logic [CW-1:0] cnt_r;
    logic          busy_r;
    logic          done_r;
    logic          sat_r;
    logic [QW-1:0] res_r;

    logic [XW-1:0] dvd_ext_s;
    logic [XW-1:0] dsh0_s;
    logic [XW-1:0] rem_in_s;
    logic [XW-1:0] dsh_in_s;
    logic [XW:0]   step_s;

    // One restoring step: {new remainder, quotient bit}.
    function automatic logic [XW:0] div_step(input logic [XW-1:0] rem,
                                             input logic [XW-1:0] dsh);
        logic [XW:0] res;
        if (rem >= dsh) begin
            res = {rem - dsh, 1'b1};
        end else begin
            res = {rem, 1'b0};
        end
        return res;
    endfunction

    // Step operands: fresh operands on the load edge, working registers after.
    always_comb begin
        dvd_ext_s = XW'(dividend);
        dsh0_s    = XW'(divisor) << QW;
        if (busy_r) begin
            rem_in_s = rem_r;
            dsh_in_s = dsh_r;
        end else begin
            rem_in_s = dvd_ext_s;
            dsh_in_s = dsh0_s;
        end
        step_s = div_step(rem_in_s, dsh_in_s);
    end

    // Division sequencer; bit QW on load, bits QW-1..0 on the following edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_r  <= {XW{1'b0}};
            dsh_r  <= {XW{1'b0}};
            q_r    <= {QW{1'b0}};
            cnt_r  <= {CW{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
            sat_r  <= 1'b0;
            res_r  <= {QW{1'b0}};
        end else if (abort) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (busy_r) begin
            rem_r <= step_s[XW:1];
            dsh_r <= dsh_r >> 1;
            q_r   <= {q_r[QW-2:0], step_s[0]};
            cnt_r <= cnt_r - CW'(1);
            if (cnt_r == CW'(1)) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
                res_r  <= sat_r ? Q_ALL_ONES : {q_r[QW-2:0], step_s[0]};
            end else begin
                done_r <= 1'b0;
            end
        end else if (start) begin
            // Quotient >= 2^QW exactly when dividend >= divisor << QW.
            sat_r  <= (dvd_ext_s >= dsh0_s);
            rem_r  <= step_s[XW:1];
            dsh_r  <= dsh0_s >> 1;
            q_r    <= {{(QW-1){1'b0}}, step_s[0]};
            cnt_r  <= CW'(QW);
            busy_r <= 1'b1;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign quotient = res_r;

endmodule

// File: rtl/zero_cross_freq_meter.sv
// ----------------------------------------------------------------------------
// zero_cross_freq_meter
// Times rising zero crossings of a signed sample stream (one sample per lrclk)
// over 2^LOG2PERIODS periods and converts the tick count into a phase
// increment word: freq = (2^LOG2PERIODS << PHASESIZE) / ticks.
// Build option: define ZCFM_ROUND_EN to round the quotient to nearest
// (ticks/2 added to the dividend); otherwise the quotient truncates.
// Ports:
//   lrclk  : sample clock, one sample per rising edge
//   reset  : synchronous active-high reset
//   in     : signed two's-complement sample
//   freq   : last measured phase increment (0 after reset/timeout)
//   valid  : one-cycle pulse when freq updates
//   locked : a measurement is current and no timeout has occurred
// ----------------------------------------------------------------------------
module zero_cross_freq_meter
    import zero_cross_freq_meter_pkg::*;
#(
    parameter int                 BITSIZE     = ZCFM_BITSIZE,
    parameter int                 PHASESIZE   = ZCFM_PHASESIZE,
    parameter int                 LOG2PERIODS = ZCFM_LOG2PERIODS,
    parameter int                 COUNTSIZE   = ZCFM_COUNTSIZE,
    parameter logic [BITSIZE-1:0] HYST        = BITSIZE'(ZCFM_HYST)
) (
    input  logic                      lrclk,
    input  logic                      reset,
    input  logic signed [BITSIZE-1:0] in,
    output logic [PHASESIZE-1:0]      freq,
    output logic                      valid,
    output logic                      locked
);

    localparam int NPER  = 2 ** LOG2PERIODS;
    localparam int XCW   = LOG2PERIODS + 1;
    localparam int DVD_W = zcfm_dividend_w(PHASESIZE, LOG2PERIODS);
    // Extra headroom so the rounding term ticks/2 can never overflow.
    localparam int NUM_W = zcfm_max(DVD_W, COUNTSIZE) + 1;

    localparam logic signed [BITSIZE-1:0] HYST_P = $signed(HYST);
    localparam logic signed [BITSIZE-1:0] HYST_N = -HYST_P;

    localparam logic [COUNTSIZE-1:0] TICK_ZERO = {COUNTSIZE{1'b0}};
    localparam logic [COUNTSIZE-1:0] TICK_ONE  = COUNTSIZE'(1);
    localparam logic [COUNTSIZE-1:0] TICK_MAX  = {COUNTSIZE{1'b1}};
    localparam logic [XCW-1:0]       XCNT_ZERO = {XCW{1'b0}};
    localparam logic [XCW-1:0]       XCNT_LAST = XCW'(NPER - 1);
    localparam logic [NUM_W-1:0]     DVD_BASE  = NUM_W'(NPER) << PHASESIZE;

    zcfm_state_e state_r;
    zcfm_state_e state_nx;

    logic                 neg_r;
    logic [COUNTSIZE-1:0] tick_r;
    logic [COUNTSIZE-1:0] tick_nx;
    logic [XCW-1:0]       xcnt_r;
    logic [XCW-1:0]       xcnt_nx;
    logic [COUNTSIZE-1:0] ticks_r;
    logic [COUNTSIZE-1:0] ticks_nx;
    logic                 start_r;
    logic                 start_nx;
    logic                 timeout_s;

    logic [PHASESIZE-1:0] freq_r;
    logic                 valid_r;
    logic                 locked_r;

    logic                 above_s;
    logic                 below_s;
    logic                 cross_s;
    logic                 div_idle_s;
    logic                 div_busy_s;
    logic                 div_done_s;
    logic [PHASESIZE-1:0] div_q_s;
    logic [NUM_W-1:0]     dvd_s;

    assign above_s = (in > HYST_P);
    assign below_s = (in < HYST_N);
    assign cross_s = neg_r && above_s;

    // A start request still in flight to the divider counts as busy.
    assign div_idle_s = !div_busy_s && !start_r;

`ifdef ZCFM_ROUND_EN
    assign dvd_s = DVD_BASE + NUM_W'(ticks_r >> 1);
`else
    assign dvd_s = DVD_BASE;
`endif

    // Polarity tracker with hysteresis band; holds inside the band.
    always_ff @(posedge lrclk) begin
        if (reset) begin
            neg_r <= 1'b0;
        end else if (below_s) begin
            neg_r <= 1'b1;
        end else if (above_s) begin
            neg_r <= 1'b0;
        end else begin
            neg_r <= neg_r;
        end
    end

    // Measurement FSM next-state: window counting, completion and timeout.
    always_comb begin
        state_nx  = state_r;
        tick_nx   = tick_r;
        xcnt_nx   = xcnt_r;
        ticks_nx  = ticks_r;
        start_nx  = 1'b0;
        timeout_s = 1'b0;
        case (state_r)
            HUNT: begin
                if (cross_s) begin
                    tick_nx  = TICK_ONE;
                    xcnt_nx  = XCNT_ZERO;
                    state_nx = MEASURE;
                end else begin
                    state_nx = HUNT;
                end
            end
            MEASURE: begin
                if (cross_s) begin
                    if (xcnt_r == XCNT_LAST) begin
                        // Window closes; tick_r is the crossing-to-crossing distance.
                        tick_nx = TICK_ONE;
                        xcnt_nx = XCNT_ZERO;
                        if (div_idle_s) begin
                            start_nx = 1'b1;
                            ticks_nx = tick_r;
                        end else begin
                            start_nx = 1'b0;
                        end
                    end else begin
                        xcnt_nx = xcnt_r + XCW'(1);
                        // A crossing beats timeout; hold at all-ones rather than wrap.
                        if (tick_r == TICK_MAX) begin
                            tick_nx = tick_r;
                        end else begin
                            tick_nx = tick_r + TICK_ONE;
                        end
                    end
                end else if (tick_r == TICK_MAX) begin
                    timeout_s = 1'b1;
                    tick_nx   = TICK_ZERO;
                    xcnt_nx   = XCNT_ZERO;
                    state_nx  = HUNT;
                end else begin
                    tick_nx = tick_r + TICK_ONE;
                end
            end
            default: begin
                tick_nx  = TICK_ZERO;
                xcnt_nx  = XCNT_ZERO;
                state_nx = HUNT;
            end
        endcase
    end

    // Measurement FSM state and window registers.
    always_ff @(posedge lrclk) begin
        if (reset) begin
            state_r <= HUNT;
            tick_r  <= TICK_ZERO;
            xcnt_r  <= XCNT_ZERO;
            ticks_r <= TICK_ZERO;
            start_r <= 1'b0;
        end else begin
            state_r <= state_nx;
            tick_r  <= tick_nx;
            xcnt_r  <= xcnt_nx;
            ticks_r <= ticks_nx;
            start_r <= start_nx;
        end
    end

    seq_divider #(
        .NW (NUM_W),
        .DW (COUNTSIZE),
        .QW (PHASESIZE)
    ) u_div (
        .clk      (lrclk),
        .reset    (reset),
        .abort    (timeout_s),
        .start    (start_r),
        .dividend (dvd_s),
        .divisor  (ticks_r),
        .busy     (div_busy_s),
        .done     (div_done_s),
        .quotient (div_q_s)
    );

    // Result registers; timeout clears and overrides a coincident completion.
    always_ff @(posedge lrclk) begin
        if (reset) begin
            freq_r   <= {PHASESIZE{1'b0}};
            valid_r  <= 1'b0;
            locked_r <= 1'b0;
        end else if (timeout_s) begin
            freq_r   <= {PHASESIZE{1'b0}};
            valid_r  <= 1'b0;
            locked_r <= 1'b0;
        end else if (div_done_s) begin
            freq_r   <= div_q_s;
            valid_r  <= 1'b1;
            locked_r <= 1'b1;
        end else begin
            valid_r  <= 1'b0;
        end
    end

    assign freq   = freq_r;
    assign valid  = valid_r;
    assign locked = locked_r;

endmodule

// File: tb/tb_zero_cross_freq_meter.sv
// ----------------------------------------------------------------------------
// Self-checking bench for zero_cross_freq_meter. Square waves with random
// per-sample amplitude, a sine loopback, reset during a division, and a
// sub-threshold timeout. Expected values come from the measurement rules:
// ticks = 4*period, freq = (4<<16)/ticks (rounded when ZCFM_ROUND_EN),
// accepted windows spaced by the first multiple of ticks that is >= 18.
// ----------------------------------------------------------------------------
module tb_zero_cross_freq_meter;

    localparam int BITSIZE     = 24;
    localparam int PHASESIZE   = 16;
    localparam int LOG2PERIODS = 2;
    localparam int COUNTSIZE   = 12;
    localparam int NPER        = 4;
    localparam int MINSP       = PHASESIZE + 2;
    localparam int AMP_LO      = 32'h010001;
    localparam int AMP_HI      = 32'h7FFFFF;

    logic                      lrclk = 1'b0;
    logic                      reset = 1'b1;
    logic signed [BITSIZE-1:0] in_s  = 24'sd0;
    logic [PHASESIZE-1:0]      freq;
    logic                      valid;
    logic                      locked;

    int checks = 0;
    int errors = 0;
    int sq_i   = 0;
    int cyc    = 0;

    always #5 lrclk = ~lrclk;

    zero_cross_freq_meter #(
        .BITSIZE     (BITSIZE),
        .PHASESIZE   (PHASESIZE),
        .LOG2PERIODS (LOG2PERIODS),
        .COUNTSIZE   (COUNTSIZE),
        .HYST        (24'h010000)
    ) dut (
        .lrclk  (lrclk),
        .reset  (reset),
        .in     (in_s),
        .freq   (freq),
        .valid  (valid),
        .locked (locked)
    );

    task automatic tick_sample(input logic signed [BITSIZE-1:0] s);
        in_s = s;
        @(posedge lrclk);
        #1;
        cyc++;
    endtask

    function automatic logic signed [BITSIZE-1:0] sq_sample(input int n, input int idx,
                                                            input int lo, input int hi);
        logic signed [BITSIZE-1:0] v;
        v = BITSIZE'($urandom_range(hi, lo));
        if ((idx % n) < (n / 2)) begin
            return v;
        end else begin
            return -v;
        end
    endfunction

    function automatic int unsigned exp_freq(input int unsigned ticks);
        longint unsigned num;
        longint unsigned q;
        num = 64'(NPER) << PHASESIZE;
`ifdef ZCFM_ROUND_EN
        num = num + 64'(ticks / 2);
`endif
        q = num / 64'(ticks);
        if (q > 64'd65535) q = 64'd65535;
        return 32'(q);
    endfunction

    function automatic int exp_spacing(input int w);
        int sp;
        sp = w;
        while (sp < MINSP) sp += w;
        return sp;
    endfunction

    task automatic run_square(input int n, input int nvalid, input string name);
        int got;
        int last;
        int budget;
        int sp;
        int unsigned ef;
        got    = 0;
        last   = 0;
        sp     = exp_spacing(4 * n);
        ef     = exp_freq(32'(4 * n));
        budget = (nvalid + 4) * sp + 8 * n + 64;
        sq_i   = 0;
        for (int s = 0; s < budget && got < nvalid; s++) begin
            tick_sample(sq_sample(n, sq_i, AMP_LO, AMP_HI));
            sq_i++;
            if (valid) begin
                if (got >= 3) begin
                    checks++;
                    if (freq !== 16'(ef)) begin
                        errors++;
                        $display("FAIL %s freq got %0d want %0d", name, freq, ef);
                    end
                    checks++;
                    if (locked !== 1'b1) begin
                        errors++;
                        $display("FAIL %s locked got %b want 1", name, locked);
                    end
                    if (got >= 4) begin
                        checks++;
                        if (cyc - last != sp) begin
                            errors++;
                            $display("FAIL %s valid_spacing got %0d want %0d", name, cyc - last, sp);
                        end
                    end
                end
                last = cyc;
                got++;
            end
        end
        checks++;
        if (got < nvalid) begin
            errors++;
            $display("FAIL %s valid_count got %0d want %0d", name, got, nvalid);
        end
    endtask

    task automatic test_reset;
        int nval;
        reset = 1'b1;
        repeat (3) tick_sample(24'sd0);
        checks += 3;
        if (freq !== 16'd0)   begin errors++; $display("FAIL reset_freq got %0d want 0", freq); end
        if (valid !== 1'b0)   begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
        if (locked !== 1'b0)  begin errors++; $display("FAIL reset_locked got %b want 0", locked); end
        reset = 1'b0;
        nval  = 0;
        for (int s = 0; s < 50; s++) begin
            tick_sample(24'sd0);
            if (valid) nval++;
        end
        checks += 2;
        if (nval != 0)       begin errors++; $display("FAIL idle_valid got %0d want 0", nval); end
        if (locked !== 1'b0) begin errors++; $display("FAIL idle_locked got %b want 0", locked); end
    endtask

    task automatic test_square;
        run_square(64, 6, "square64");
        checks++;
        if (freq !== 16'd1024) begin
            errors++;
            $display("FAIL square64_literal got %0d want 1024", freq);
        end
    endtask

    task automatic test_overrun;
        run_square(4, 8, "overrun4");
        checks++;
        if (freq !== 16'd16384) begin
            errors++;
            $display("FAIL overrun_literal got %0d want 16384", freq);
        end
    endtask

    task automatic test_rounding;
        run_square(3, 7, "round3");
        checks++;
        if (freq !== 16'd21845) begin
            errors++;
            $display("FAIL round3_literal got %0d want 21845", freq);
        end
        run_square(6, 7, "round6");
        checks++;
`ifdef ZCFM_ROUND_EN
        if (freq !== 16'd10923) begin
            errors++;
            $display("FAIL round6_literal got %0d want 10923", freq);
        end
`else
        if (freq !== 16'd10922) begin
            errors++;
            $display("FAIL round6_literal got %0d want 10922", freq);
        end
`endif
    endtask

    task automatic test_random_periods;
        int n;
        run_square(5, 6, "period5");
        for (int k = 0; k < 2; k++) begin
            n = $urandom_range(40, 6);
            run_square(n, 6, "period_rand");
        end
    endtask

    task automatic test_loopback;
        logic [15:0] ph;
        int got;
        int diff;
        real x;
        ph  = 16'h0000;
        got = 0;
        for (int s = 0; s < 5000 && got < 6; s++) begin
            x = 4194304.0 * $sin(2.0 * 3.14159265358979 * real'(ph) / 65536.0);
            tick_sample(BITSIZE'($rtoi(x)));
            ph = ph + 16'h0200;
            if (valid) begin
                if (got >= 3) begin
                    diff = int'(freq) - 32'h0200;
                    checks++;
                    if (diff > 1 || diff < -1) begin
                        errors++;
                        $display("FAIL loopback freq got %0d want 512+-1", freq);
                    end
                    checks++;
                    if (locked !== 1'b1) begin
                        errors++;
                        $display("FAIL loopback locked got %b want 1", locked);
                    end
                end
                got++;
            end
        end
        checks++;
        if (got < 6) begin
            errors++;
            $display("FAIL loopback valid_count got %0d want 6", got);
        end
    endtask

    task automatic test_reset_mid;
        int found;
        int delta;
        run_square(64, 4, "pre_reset");
        // The last valid is 18 samples after a window close; the next close
        // is 238 samples on, so 245 samples on the divider is mid-division.
        for (int s = 0; s < 244; s++) begin
            tick_sample(sq_sample(64, sq_i, AMP_LO, AMP_HI));
            sq_i++;
        end
        checks += 2;
        if (freq !== 16'd1024) begin errors++; $display("FAIL pre_reset_freq got %0d want 1024", freq); end
        if (locked !== 1'b1)   begin errors++; $display("FAIL pre_reset_locked got %b want 1", locked); end
        reset = 1'b1;
        tick_sample(sq_sample(64, sq_i, AMP_LO, AMP_HI));
        sq_i++;
        reset = 1'b0;
        checks += 3;
        if (freq !== 16'd0)  begin errors++; $display("FAIL midreset_freq got %0d want 0", freq); end
        if (locked !== 1'b0) begin errors++; $display("FAIL midreset_locked got %b want 0", locked); end
        if (valid !== 1'b0)  begin errors++; $display("FAIL midreset_valid got %b want 0", valid); end
        found = 0;
        delta = 0;
        for (int s = 1; s <= 600 && found == 0; s++) begin
            tick_sample(sq_sample(64, sq_i, AMP_LO, AMP_HI));
            sq_i++;
            if (valid) begin
                found = 1;
                delta = s;
            end
        end
        checks += 2;
        if (found == 0 || delta < 274 || delta > 338) begin
            errors++;
            $display("FAIL postreset_first_valid got %0d want 274..338", delta);
        end
        if (freq !== 16'd1024) begin
            errors++;
            $display("FAIL postreset_freq got %0d want 1024", freq);
        end
    endtask

    task automatic test_timeout;
        int nval;
        run_square(64, 4, "pre_timeout");
        nval = 0;
        for (int s = 1; s <= 4300; s++) begin
            tick_sample(sq_sample(64, sq_i, 32'h008000, 32'h008000));
            sq_i++;
            if (s >= 40 && valid) nval++;
            if (s == 3000) begin
                checks += 2;
                if (locked !== 1'b1)   begin errors++; $display("FAIL subthr_early_locked got %b want 1", locked); end
                if (freq !== 16'd1024) begin errors++; $display("FAIL subthr_early_freq got %0d want 1024", freq); end
            end
        end
        checks += 3;
        if (locked !== 1'b0) begin errors++; $display("FAIL timeout_locked got %b want 0", locked); end
        if (freq !== 16'd0)  begin errors++; $display("FAIL timeout_freq got %0d want 0", freq); end
        if (nval != 0)       begin errors++; $display("FAIL subthr_valid got %0d want 0", nval); end
    endtask

    initial begin
        test_reset;
        test_square;
        test_overrun;
        test_rounding;
        test_random_periods;
        test_loopback;
        test_reset_mid;
        test_timeout;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
